// File: rtl/load_store_unit.sv
// Memory stage: turns the ALU result into a word-aligned req/ack data-memory access,
// places store lanes, extracts and extends load lanes, and stalls the core meanwhile.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  stall,
  output logic                  done,
  output logic                  fault,
  output logic [1:0]            fault_cause,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       ld_size;
  logic [1:0]       ld_off;
  logic             ld_uns;

  logic             is_req;
  logic             f3_ok;
  logic             misaligned;
  logic [35:0]      st_lanes;

  // Picks the addressed lane out of the read word and extends it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Returns {byte_enables, replicated_store_data}.
  function automatic logic [35:0] store_lanes(input logic [31:0] d,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size);
    logic [35:0] r;
    case (size)
      2'b00:   r = {4'b0001 << off, {4{d[7:0]}}};
      2'b01:   r = {(off[1] ? 4'b1100 : 4'b0011), {2{d[15:0]}}};
      default: r = {4'b1111, d};
    endcase
    return r;
  endfunction

  assign is_req = mem_read | mem_write;

  // A simultaneous read and write is handled as a store, so store-only sizes apply.
  always_comb begin
    f3_ok = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = ~mem_write;
      default:                f3_ok = 1'b0;
    endcase
  end

  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

  assign st_lanes = store_lanes(wdata, addr[1:0], funct3[1:0]);

  assign stall = ((state == IDLE) && is_req) || (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      ld_size     <= '0;
      ld_off      <= '0;
      ld_uns      <= 1'b0;
      rdata       <= '0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_cause <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (is_req) begin
            if (!f3_ok) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_ILLEGAL;
              state       <= ERR;
            end else if (misaligned) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              state       <= ERR;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_wdata <= mem_write ? st_lanes[31:0] : 32'b0;
              dmem_be    <= mem_write ? st_lanes[35:32] : 4'b0000;
              ld_size    <= funct3[1:0];
              ld_off     <= addr[1:0];
              ld_uns     <= funct3[2];
              wait_cnt   <= '0;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          // An ack in the cycle the wait limit is reached still completes the access.
          if (dmem_ack) begin
            if (!dmem_we) rdata <= load_extend(dmem_rdata, ld_off, ld_size, ld_uns);
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            dmem_be  <= 4'b0000;
            wait_cnt <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_be     <= 4'b0000;
            wait_cnt    <= '0;
            fault       <= 1'b1;
            fault_cause <= CAUSE_TIMEOUT;
            state       <= ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus queues expected memory requests and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [2:0]    funct3 = 3'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          stall;
  logic          done;
  logic          fault;
  logic [1:0]    fault_cause;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_rdata = '0;
  logic          dmem_ack = 1'b0;

  load_store_unit #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .done(done), .fault(fault), .fault_cause(fault_cause), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          id;
    logic        is_fault;
    logic [1:0]  cause;
    logic        chk_rd;
    logic [31:0] rd;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad = 0;
  int req_count = 0;
  int req_cycles = 0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares requests on their first cycle and completions on their pulse.
  initial begin
    req_t  r;
    resp_t e;
    logic  req_seen;
    req_seen = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall) stall_cycles++;
        if (dmem_req) begin
          req_cycles++;
          if (!req_seen) begin
            req_count++;
            req_seen = 1'b1;
            if (req_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_req: got addr 0x%08h want none", dmem_addr);
            end else begin
              r = req_q.pop_front();
              check($sformatf("req%0d_addr", r.id), dmem_addr, r.addr);
              check($sformatf("req%0d_we", r.id), 32'(dmem_we), 32'(r.we));
              check($sformatf("req%0d_be", r.id), 32'(dmem_be), 32'(r.be));
              if (r.we) check($sformatf("req%0d_wdata", r.id), dmem_wdata, r.wdata);
            end
          end
        end else begin
          req_seen = 1'b0;
        end
        if (done || fault) begin
          check("stall_at_end", 32'(stall), 32'd0);
          if (resp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_resp: got done=%0b fault=%0b want none", done, fault);
          end else begin
            e = resp_q.pop_front();
            check($sformatf("resp%0d_done", e.id), 32'(done), 32'(!e.is_fault));
            check($sformatf("resp%0d_fault", e.id), 32'(fault), 32'(e.is_fault));
            if (e.is_fault) begin
              check($sformatf("resp%0d_cause", e.id), 32'(fault_cause), 32'(e.cause));
              check($sformatf("resp%0d_noreq", e.id), 32'(dmem_req), 32'd0);
            end
            if (e.chk_rd) check($sformatf("resp%0d_rdata", e.id), rdata, e.rd);
          end
        end
      end
    end
  end

  // One complete access; ack_after = REQ cycles without ack before the ack cycle.
  task automatic do_access(input int id, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int ack_after,
                           input logic [31:0] mem, input logic flt, input logic [1:0] cause,
                           input logic [31:0] exp_rd, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
    req_t  r;
    resp_t e;
    if (!flt) begin
      r.id = id; r.addr = {a[31:2], 2'b00}; r.we = wr; r.be = exp_be; r.wdata = exp_wd;
      req_q.push_back(r);
    end
    e.id = id; e.is_fault = flt; e.cause = cause; e.chk_rd = rd && !wr && !flt; e.rd = exp_rd;
    resp_q.push_back(e);
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    if (flt) begin
      @(posedge clk); #1;
    end else begin
      repeat (ack_after) begin @(posedge clk); #1; end
      dmem_ack = 1'b1; dmem_rdata = mem;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    base;
    req_t  r;
    resp_t e;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_cause", 32'(fault_cause), 32'd0);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'h0);
    check("rst_wdata", dmem_wdata, 32'h0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;

    // Word store with one wait cycle: stall covers accept + two REQ cycles.
    stall_cycles = 0;
    do_access(1, 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0, 0, 2'b00, 32'h0, 4'hF, 32'hDEADBEEF);
    check("t1_stall_cycles", 32'(stall_cycles), 32'd3);

    // Loads: lane extraction with sign/zero extension.
    do_access(2, 1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233, 0, 2'b00, 32'hFFFFFF80, 4'h0, 32'h0);
    do_access(3, 1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80112233, 0, 2'b00, 32'h00000080, 4'h0, 32'h0);
    do_access(4, 1, 0, 3'b101, 32'h102, 32'h0, 0, 32'h80112233, 0, 2'b00, 32'h00008011, 4'h0, 32'h0);
    do_access(5, 1, 0, 3'b001, 32'h102, 32'h0, 1, 32'h80112233, 0, 2'b00, 32'hFFFF8011, 4'h0, 32'h0);
    do_access(6, 1, 0, 3'b000, 32'h100, 32'h0, 2, 32'h80112233, 0, 2'b00, 32'h00000033, 4'h0, 32'h0);
    do_access(7, 1, 0, 3'b001, 32'h100, 32'h0, 0, 32'h80112233, 0, 2'b00, 32'h00002233, 4'h0, 32'h0);
    do_access(8, 1, 0, 3'b010, 32'h104, 32'h0, 3, 32'h12345678, 0, 2'b00, 32'h12345678, 4'h0, 32'h0);

    // Stores: lane placement; rdata must keep the last load value.
    do_access(9, 0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'hFFFFFFFF, 0, 2'b00, 32'h0, 4'hC, 32'hABCDABCD);
    check("t3_rdata_kept", rdata, 32'h12345678);
    do_access(10, 0, 1, 3'b000, 32'h101, 32'h00000012, 0, 32'h0, 0, 2'b00, 32'h0, 4'h2, 32'h12121212);
    do_access(11, 0, 1, 3'b000, 32'h103, 32'hFFFFFF9A, 1, 32'h0, 0, 2'b00, 32'h0, 4'h8, 32'h9A9A9A9A);
    do_access(12, 0, 1, 3'b001, 32'h100, 32'h11112222, 0, 32'h0, 0, 2'b00, 32'h0, 4'h3, 32'h22222222);
    do_access(13, 1, 1, 3'b010, 32'h108, 32'h0BADF00D, 0, 32'h0, 0, 2'b00, 32'h0, 4'hF, 32'h0BADF00D);
    check("t3_rdata_kept2", rdata, 32'h12345678);

    // Faults: no memory request may be issued.
    base = req_count;
    do_access(14, 1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0, 1, 2'b01, 32'h0, 4'h0, 32'h0);
    do_access(15, 0, 1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1, 2'b10, 32'h0, 4'h0, 32'h0);
    do_access(16, 1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1, 2'b10, 32'h0, 4'h0, 32'h0);
    do_access(17, 0, 1, 3'b001, 32'h101, 32'h0, 0, 32'h0, 1, 2'b01, 32'h0, 4'h0, 32'h0);
    do_access(18, 1, 1, 3'b101, 32'h100, 32'h0, 0, 32'h0, 1, 2'b10, 32'h0, 4'h0, 32'h0);
    do_access(19, 1, 0, 3'b111, 32'h102, 32'h0, 0, 32'h0, 1, 2'b10, 32'h0, 4'h0, 32'h0);
    check("t4_no_req", 32'(req_count - base), 32'd0);
    check("t4_rdata_kept", rdata, 32'h12345678);

    // Timeout: request held exactly MAX_WAIT cycles, then fault 11.
    r.id = 20; r.addr = 32'h200; r.we = 1'b0; r.be = 4'h0; r.wdata = 32'h0;
    req_q.push_back(r);
    e.id = 20; e.is_fault = 1'b1; e.cause = 2'b11; e.chk_rd = 1'b0; e.rd = 32'h0;
    resp_q.push_back(e);
    base = req_cycles;
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (MW + 2) @(posedge clk);
    #1;
    check("t5_req_cycles", 32'(req_cycles - base), 32'(MW));
    check("t5_req_dropped", 32'(dmem_req), 32'd0);
    check("t5_rdata_kept", rdata, 32'h12345678);

    // Asynchronous reset in the middle of a request.
    r.id = 21; r.addr = 32'h300; r.we = 1'b0; r.be = 4'h0; r.wdata = 32'h0;
    req_q.push_back(r);
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_req", 32'(dmem_req), 32'd0);
    check("t6_rst_stall", 32'(stall), 32'd0);
    check("t6_rst_rdata", rdata, 32'h0);
    check("t6_rst_addr", dmem_addr, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // mem_read held through DONE must issue only one access.
    r.id = 22; r.addr = 32'h200; r.we = 1'b0; r.be = 4'h0; r.wdata = 32'h0;
    req_q.push_back(r);
    e.id = 22; e.is_fault = 1'b0; e.cause = 2'b00; e.chk_rd = 1'b1; e.rd = 32'hCAFEF00D;
    resp_q.push_back(e);
    base = req_count;
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h200;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_single_access", 32'(req_count - base), 32'd1);
    check("t6_rdata_held", rdata, 32'hCAFEF00D);

    check("end_req_q_empty", 32'(req_q.size()), 32'd0);
    check("end_resp_q_empty", 32'(resp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
